// File: rtl/opex_forward_stage.sv
// OP->EX pipeline register with MA/WB forward resolution.
// Holds resolved operands across stalls; counts inserted bubbles.
module opex_forward_stage #(
  parameter int CNT_W = 16
) (
  input  logic             s_clk_i,
  input  logic             s_resetn_i,
  input  logic             s_stall_i,
  input  logic             s_flush_i,
  input  logic [31:0]      s_operand1_i,
  input  logic [31:0]      s_operand2_i,
  input  logic [3:0]       s_fwd_i,
  input  logic             s_bubble_i,
  input  logic [6:0]       s_ictrl_i,
  input  logic [4:0]       s_rd_i,
  input  logic [31:0]      s_exma_val_i,
  input  logic [31:0]      s_mawb_val_i,
  output logic [31:0]      s_opex_op1_o,
  output logic [31:0]      s_opex_op2_o,
  output logic [6:0]       s_opex_ictrl_o,
  output logic [4:0]       s_opex_rd_o,
  output logic [CNT_W-1:0] s_bubble_cnt_o
);

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  fwd;
    logic [6:0]  ictrl;
    logic [4:0]  rd;
  } opex_t;

  opex_t            ex_q;
  logic [CNT_W-1:0] cnt_q;
  logic             bump;

  assign bump = s_bubble_i & ~s_stall_i & ~s_flush_i;

  // MA holds the younger producer, so it wins over WB.
  always_comb begin
    s_opex_op1_o = ex_q.op1;
    s_opex_op2_o = ex_q.op2;
    if (ex_q.fwd[0])
      s_opex_op1_o = s_exma_val_i;
    else if (ex_q.fwd[2])
      s_opex_op1_o = s_mawb_val_i;
    if (ex_q.fwd[1])
      s_opex_op2_o = s_exma_val_i;
    else if (ex_q.fwd[3])
      s_opex_op2_o = s_mawb_val_i;
  end

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      ex_q <= '0;
    end else if (s_flush_i) begin
      ex_q <= '0;
    end else if (s_stall_i) begin
      // Capture the forwarded value now; the producer leaves MA next.
      ex_q.op1 <= s_opex_op1_o;
      ex_q.op2 <= s_opex_op2_o;
      ex_q.fwd <= '0;
    end else if (s_bubble_i) begin
      ex_q.fwd   <= '0;
      ex_q.ictrl <= '0;
      ex_q.rd    <= '0;
    end else begin
      ex_q.op1   <= s_operand1_i;
      ex_q.op2   <= s_operand2_i;
      ex_q.fwd   <= s_fwd_i;
      ex_q.ictrl <= s_ictrl_i;
      ex_q.rd    <= s_rd_i;
    end
  end

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i)
      cnt_q <= '0;
    else if (bump && (cnt_q != {CNT_W{1'b1}}))
      cnt_q <= cnt_q + 1'b1;
  end

  assign s_opex_ictrl_o = ex_q.ictrl;
  assign s_opex_rd_o    = ex_q.rd;
  assign s_bubble_cnt_o = cnt_q;

endmodule

// File: tb/tb_opex_forward_stage.sv
// Directed bench for opex_forward_stage.
// Vector table for forwarding, hand sequences for stall/bubble/flush/reset.
module tb_opex_forward_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, bubble;
  logic [31:0] opnd1, opnd2, exma, mawb;
  logic [3:0]  fwd;
  logic [6:0]  ictrl;
  logic [4:0]  rd;

  logic [31:0] op1, op2, op1_s, op2_s;
  logic [6:0]  ictrl_o, ictrl_s;
  logic [4:0]  rd_o, rd_s;
  logic [15:0] cnt;
  logic [1:0]  cnt_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  opex_forward_stage dut (
    .s_clk_i(clk), .s_resetn_i(rst_n),
    .s_stall_i(stall), .s_flush_i(flush),
    .s_operand1_i(opnd1), .s_operand2_i(opnd2),
    .s_fwd_i(fwd), .s_bubble_i(bubble),
    .s_ictrl_i(ictrl), .s_rd_i(rd),
    .s_exma_val_i(exma), .s_mawb_val_i(mawb),
    .s_opex_op1_o(op1), .s_opex_op2_o(op2),
    .s_opex_ictrl_o(ictrl_o), .s_opex_rd_o(rd_o),
    .s_bubble_cnt_o(cnt)
  );

  opex_forward_stage #(.CNT_W(2)) dut_s (
    .s_clk_i(clk), .s_resetn_i(rst_n),
    .s_stall_i(stall), .s_flush_i(flush),
    .s_operand1_i(opnd1), .s_operand2_i(opnd2),
    .s_fwd_i(fwd), .s_bubble_i(bubble),
    .s_ictrl_i(ictrl), .s_rd_i(rd),
    .s_exma_val_i(exma), .s_mawb_val_i(mawb),
    .s_opex_op1_o(op1_s), .s_opex_op2_o(op2_s),
    .s_opex_ictrl_o(ictrl_s), .s_opex_rd_o(rd_s),
    .s_bubble_cnt_o(cnt_s)
  );

  typedef struct {
    logic [31:0] o1, o2;
    logic [3:0]  f;
    logic [6:0]  ic;
    logic [4:0]  r;
    logic [31:0] ma, wb;
    logic [31:0] e1, e2;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; flush = 0; bubble = 0;
    opnd1 = '0; opnd2 = '0; fwd = '0;
    ictrl = '0; rd = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_op1"}, op1, 32'h0);
    chk({tag, "_op2"}, op2, 32'h0);
    chk({tag, "_ictrl"}, {25'd0, ictrl_o}, 32'h0);
    chk({tag, "_rd"}, {27'd0, rd_o}, 32'h0);
    chk({tag, "_cnt"}, {16'd0, cnt}, 32'h0);
  endtask

  initial begin
    tbl[0] = '{32'h10, 32'h20, 4'b0000, 7'h01, 5'd3,
               32'hDEAD, 32'hBEEF, 32'h10, 32'h20};
    tbl[1] = '{32'h11, 32'h22, 4'b0001, 7'h02, 5'd4,
               32'hDEAD, 32'hBEEF, 32'hDEAD, 32'h22};
    tbl[2] = '{32'h13, 32'h24, 4'b0101, 7'h03, 5'd5,
               32'hDEAD, 32'hBEEF, 32'hDEAD, 32'h24};
    tbl[3] = '{32'h15, 32'h26, 4'b0100, 7'h04, 5'd6,
               32'hDEAD, 32'hBEEF, 32'hBEEF, 32'h26};
    tbl[4] = '{32'h17, 32'h28, 4'b1010, 7'h05, 5'd7,
               32'h1111, 32'h2222, 32'h17, 32'h1111};
    tbl[5] = '{32'h19, 32'h2A, 4'b1000, 7'h06, 5'd8,
               32'h1111, 32'h2222, 32'h19, 32'h2222};
    tbl[6] = '{32'h1B, 32'h2C, 4'b1111, 7'h7F, 5'd31,
               32'h3333, 32'h4444, 32'h3333, 32'h3333};

    idle();
    exma = 32'hDEAD; mawb = 32'hBEEF;
    rst_n = 0;
    #12;
    chk_zero("rst");
    rst_n = 1;
    #1;
    chk_zero("post_rst");

    // Forwarding table
    for (int i = 0; i < 7; i++) begin
      opnd1 = tbl[i].o1; opnd2 = tbl[i].o2;
      fwd = tbl[i].f; ictrl = tbl[i].ic; rd = tbl[i].r;
      exma = tbl[i].ma; mawb = tbl[i].wb;
      step();
      chk($sformatf("v%0d_op1", i), op1, tbl[i].e1);
      chk($sformatf("v%0d_op2", i), op2, tbl[i].e2);
      chk($sformatf("v%0d_ictrl", i), {25'd0, ictrl_o},
          {25'd0, tbl[i].ic});
      chk($sformatf("v%0d_rd", i), {27'd0, rd_o}, {27'd0, tbl[i].r});
    end
    chk("tbl_cnt", {16'd0, cnt}, 32'h0);

    // Stall captures the MA value and holds it
    opnd1 = 32'h50; opnd2 = 32'h5; fwd = 4'b0010;
    ictrl = 7'h07; rd = 5'd9; exma = 32'h1234; mawb = 32'h0;
    step();
    chk("st_load_op2", op2, 32'h1234);
    stall = 1; opnd2 = 32'h777; fwd = 4'b0000;
    ictrl = 7'h11; rd = 5'd1;
    step();
    exma = 32'h9999;
    #1;
    chk("st1_op2", op2, 32'h1234);
    chk("st1_op1", op1, 32'h50);
    for (int i = 2; i <= 3; i++) begin
      step();
      chk($sformatf("st%0d_op2", i), op2, 32'h1234);
      chk($sformatf("st%0d_ictrl", i), {25'd0, ictrl_o}, 32'h7);
      chk($sformatf("st%0d_rd", i), {27'd0, rd_o}, 32'd9);
    end

    // Bubbles, then stall+bubble does not count
    idle();
    bubble = 1; ictrl = 7'h22; rd = 5'd2;
    for (int i = 0; i < 5; i++) step();
    chk("bub_ictrl", {25'd0, ictrl_o}, 32'h0);
    chk("bub_rd", {27'd0, rd_o}, 32'h0);
    chk("bub_cnt", {16'd0, cnt}, 32'd5);
    chk("bub_cnt_sat", {30'd0, cnt_s}, 32'd3);
    stall = 1;
    step(); step();
    chk("stbub_cnt", {16'd0, cnt}, 32'd5);
    chk("stbub_ictrl", {25'd0, ictrl_o}, 32'h0);

    // Flush over stall and bubble
    idle();
    opnd1 = 32'hA1; opnd2 = 32'hA2; fwd = 4'b0001;
    ictrl = 7'h05; rd = 5'd6; exma = 32'hCAFE;
    step();
    chk("fl_pre_ictrl", {25'd0, ictrl_o}, 32'h5);
    chk("fl_pre_op1", op1, 32'hCAFE);
    stall = 1; flush = 1; bubble = 1;
    step();
    chk("fl_ictrl", {25'd0, ictrl_o}, 32'h0);
    chk("fl_rd", {27'd0, rd_o}, 32'h0);
    chk("fl_op1", op1, 32'h0);
    chk("fl_cnt", {16'd0, cnt}, 32'd5);

    // Async reset mid-stall
    idle();
    opnd1 = 32'hAA; opnd2 = 32'hBB; fwd = 4'b0001;
    ictrl = 7'h03; rd = 5'd7; exma = 32'h5555;
    step();
    stall = 1;
    step();
    chk("rs_pre_op1", op1, 32'h5555);
    #2;
    rst_n = 0;
    #1;
    chk_zero("rs_mid");
    step();
    rst_n = 1;
    idle();
    opnd1 = 32'h31; opnd2 = 32'h32;
    ictrl = 7'h09; rd = 5'd10;
    step();
    chk("rs_resume_op1", op1, 32'h31);
    chk("rs_resume_op2", op2, 32'h32);
    chk("rs_resume_ictrl", {25'd0, ictrl_o}, 32'h9);
    chk("rs_resume_rd", {27'd0, rd_o}, 32'd10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/opex_forward_stage.md
Name: opex_forward_stage

Overview:
- Consumer end of the OP-stage operand-preparation interface.
- Registers the prepared operands, forwarding bits, bubble request and control from the OP stage into the EX stage.
- Resolves the pending forwards against the MA and WB results to produce final EX operands.
- Preserves resolved values across EX stalls, and counts inserted bubbles for performance monitoring.

Parameters:
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- s_clk_i  input  1  core clock
- s_resetn_i  input  1  reset, asynchronous, active-low
- s_stall_i  input  1  hold EX-stage contents
- s_flush_i  input  1  kill the EX-stage instruction
- s_operand1_i  input  32  prepared operand 1 from OP
- s_operand2_i  input  32  prepared operand 2 from OP
- s_fwd_i  input  4  forwarding bits from OP: [0] rs1<-MA, [1] rs2<-MA, [2] rs1<-WB, [3] rs2<-WB
- s_bubble_i  input  1  bubble request from OP
- s_ictrl_i  input  7  OP instruction control
- s_rd_i  input  5  OP destination register
- s_exma_val_i  input  32  result of the instruction currently in MA
- s_mawb_val_i  input  32  result of the instruction currently in WB
- s_opex_op1_o  output  32  resolved EX operand 1
- s_opex_op2_o  output  32  resolved EX operand 2
- s_opex_ictrl_o  output  7  EX instruction control
- s_opex_rd_o  output  5  EX destination register
- s_bubble_cnt_o  output  CNT_W  count of inserted bubbles, saturating

Behaviour:
- Reset (async, s_resetn_i=0): all registers, including operands, fwd, ictrl, rd and counter, go to 0.
  - All outputs read 0 while reset is asserted and in the first cycle after release.
- Update priority each rising edge: flush > stall > bubble > load.
- Flush:
  - ictrl <= 0, fwd <= 0, rd <= 0; operands are don't-care (cleared to 0).
  - Flush wins over simultaneous stall or bubble.
- Stall without flush:
  - ictrl and rd are held.
  - Operand registers <= currently resolved s_opex_op1_o / s_opex_op2_o.
  - fwd <= 0.
  - Reason: during the stall the MA producer moves to WB, so the forwarded value is captured in the first stall cycle. Subsequent stall cycles hold it unchanged.
- Bubble without stall or flush: ictrl <= 0, fwd <= 0, rd <= 0. The counter increments.
- Normal load: operand, fwd, ictrl and rd registers <= inputs.
- Resolution (combinational from registers):
  - op1 = fwd[0] ? s_exma_val_i : fwd[2] ? s_mawb_val_i : operand1 register.
  - op2 = fwd[1] ? s_exma_val_i : fwd[3] ? s_mawb_val_i : operand2 register.
  - MA has priority over WB because it holds the younger producer.
- Latency: one cycle from OP inputs to EX registers; forward resolution adds zero cycles.
- Counter:
  - Increments by 1 only on a cycle where s_bubble_i=1, s_stall_i=0 and s_flush_i=0.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Cleared only by reset.
- Reset asserted mid-stall: everything clears immediately; no captured value survives.
- Operands with ictrl=0 (bubble/flush) never affect EX; fwd is always 0 in that case.

Test Plan:
1. Reset, then load operand1=0x10, operand2=0x20, fwd=0, ictrl=0x01 -> next cycle op1=0x10, op2=0x20, ictrl=0x01, counter=0.
2. Load fwd=4'b0001, s_exma_val_i=0xDEAD, s_mawb_val_i=0xBEEF -> op1=0xDEAD, op2=operand2. With fwd=4'b0101 (bits 0 and 2 set) -> op1=0xDEAD (MA priority).
3. Load fwd=4'b0010 with s_exma_val_i=0x1234, then stall 3 cycles while s_exma_val_i changes to 0x9999 after the first stall edge -> op2 stays 0x1234 through all stall cycles, and internal fwd=0.
4. s_bubble_i=1 for 5 cycles with no stall, then stall+bubble for 2 cycles -> ictrl=0, counter=5. With CNT_W=2, 5 bubbles -> counter=3.
5. Stall and flush asserted together with a valid EX instruction -> ictrl=0, rd=0, fwd=0 next cycle, counter unchanged.
6. Assert s_resetn_i=0 asynchronously mid-stall -> all outputs 0 before the next clock edge; release, then load resumes normally.
